prefix_adder_bist: RTL and testbench



---
 rtl/prefix_adder_bist.sv | 109 ++++++++++
 tb/tb_prefix_adder_bist.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prefix_adder_bist.sv
// prefix_adder_bist: exhaustive self-test of an N-bit adder (A,B out, S in) with LAT-aligned reference, saturating error count and first-failure capture; status on busy/done/pass/errors/fail_*
module prefix_adder_bist #(
  parameter int N    = 8,
  parameter int LAT  = 0,
  parameter int ERRW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N-1:0]    A,
  output logic [N-1:0]    B,
  input  logic [N:0]      S,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [ERRW-1:0] errors,
  output logic            fail_valid,
  output logic [N-1:0]    fail_A,
  output logic [N-1:0]    fail_B,
  output logic [N:0]      fail_S
);
  localparam int W = 3 * N + 2;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t          state;
  logic [2:0]      dcnt;
  logic [W-1:0]    cur, tap;
  logic            cap_v;
  logic [N-1:0]    cap_a, cap_b;
  logic [N:0]      cap_exp, cap_s;
  logic            mis, launch;
  assign cur    = {state == RUN, A, B, {1'b0, A} + {1'b0, B}};
  assign mis    = cap_v && (cap_s !== cap_exp);
  assign launch = start && (state == IDLE || state == DONE);
  assign pass   = done && errors == '0;
  generate
    if (LAT == 0) begin : g_comb
      assign tap = cur;
    end else begin : g_dly
      logic [W-1:0] sr [LAT];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < LAT; i++) sr[i] <= '0;
        end else begin
          sr[0] <= cur;
          for (int i = 1; i < LAT; i++) sr[i] <= sr[i-1];
        end
      end
      assign tap = sr[LAT-1];
    end
  endgenerate
  always_ff @(posedge clk) begin
    if (rst) begin
      {cap_v, cap_a, cap_b, cap_exp} <= '0;
      cap_s <= '0;
    end else begin
      {cap_v, cap_a, cap_b, cap_exp} <= tap;
      cap_s <= S;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      A          <= '0;
      B          <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      errors     <= '0;
      fail_valid <= 1'b0;
      fail_A     <= '0;
      fail_B     <= '0;
      fail_S     <= '0;
      dcnt       <= '0;
    end else if (launch) begin
      state      <= RUN;
      {A, B}     <= '0;
      busy       <= 1'b1;
      done       <= 1'b0;
      errors     <= '0;
      fail_valid <= 1'b0;
      fail_A     <= '0;
      fail_B     <= '0;
      fail_S     <= '0;
    end else begin
      if (state == RUN) begin
        if (&{A, B}) begin
          state <= DRAIN;
          dcnt  <= '0;
        end else begin
          {A, B} <= {A, B} + (2 * N)'(1);
        end
      end else if (state == DRAIN) begin
        if (dcnt == 3'(LAT)) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          dcnt <= dcnt + 3'd1;
        end
      end
      if (mis && errors != '1) errors <= errors + ERRW'(1);
      if (mis && !fail_valid) begin
        fail_valid <= 1'b1;
        fail_A     <= cap_a;
        fail_B     <= cap_b;
        fail_S     <= cap_s;
      end
    end
  end
endmodule

// File: tb/tb_prefix_adder_bist.sv
// tb_prefix_adder_bist: scoreboard bench driving three BIST instances against fault-injectable adders
module tb_prefix_adder_bist;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic st0 = 0, st1 = 0, st2 = 0;
  logic [3:0] a0, b0, a1, b1, a2, b2, fa0, fb0, fa1, fb1, fa2, fb2;
  logic [4:0] s0, s1, s2, fs0, fs1, fs2;
  logic bz0, bz1, bz2, dn0, dn1, dn2, ps0, ps1, ps2, fv0, fv1, fv2;
  logic [15:0] er0, er1;
  logic [3:0] er2;
  logic fen = 0, fval = 0;
  int fbit = 0;
  logic isreg = 0;
  logic [4:0] p1 = 0, p2 = 0, q1 = 0, q2 = 0;
  int vec = 0, mis = 0, cyc = 0, e0_0 = 0;
  logic pd0 = 0, pd1 = 0, pd2 = 0;
  typedef struct packed {
    logic [15:0] err;
    logic        nz;
    logic        fv;
    logic [3:0]  fa;
    logic [3:0]  fb;
    logic [4:0]  fs;
    logic [31:0] at;
  } exp_t;
  exp_t q0[$], q1q[$], q2q[$];

  function automatic logic [4:0] flt(input logic [4:0] x, input logic en, input int bt, input logic v);
    logic [4:0] m;
    m = 5'd1 << bt;
    return !en ? x : v ? (x | m) : (x & ~m);
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    p1 <= {1'b0, a0} + {1'b0, b0};
    p2 <= p1;
    q1 <= {1'b0, a1} + {1'b0, b1};
    q2 <= q1;
  end
  assign s0 = flt(isreg ? p2 : {1'b0, a0} + {1'b0, b0}, fen, fbit, fval);
  assign s1 = flt(q2, fen, fbit, fval);
  assign s2 = flt({1'b0, a2} + {1'b0, b2}, fen, fbit, fval);

  prefix_adder_bist #(.N(4), .LAT(0), .ERRW(16)) u0 (
    .clk(clk), .rst(rst), .start(st0), .A(a0), .B(b0), .S(s0), .busy(bz0), .done(dn0), .pass(ps0),
    .errors(er0), .fail_valid(fv0), .fail_A(fa0), .fail_B(fb0), .fail_S(fs0));
  prefix_adder_bist #(.N(4), .LAT(2), .ERRW(16)) u1 (
    .clk(clk), .rst(rst), .start(st1), .A(a1), .B(b1), .S(s1), .busy(bz1), .done(dn1), .pass(ps1),
    .errors(er1), .fail_valid(fv1), .fail_A(fa1), .fail_B(fb1), .fail_S(fs1));
  prefix_adder_bist #(.N(4), .LAT(0), .ERRW(4)) u2 (
    .clk(clk), .rst(rst), .start(st2), .A(a2), .B(b2), .S(s2), .busy(bz2), .done(dn2), .pass(ps2),
    .errors(er2), .fail_valid(fv2), .fail_A(fa2), .fail_B(fb2), .fail_S(fs2));

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] want);
    vec++;
    if (act !== want) begin
      mis++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", n, act, want, cyc);
    end
  endtask

  task automatic score(input string n, input exp_t e, input logic [15:0] er, input logic ps, input logic fv,
                       input logic [3:0] fa, input logic [3:0] fb, input logic [4:0] fs);
    if (e.nz) begin
      chk({n, ".errors_nonzero"}, 32'(er != 0), 1);
      chk({n, ".pass"}, 32'(ps), 0);
    end else begin
      chk({n, ".errors"}, 32'(er), 32'(e.err));
      chk({n, ".pass"}, 32'(ps), 32'(e.err == 0));
      chk({n, ".fail_valid"}, 32'(fv), 32'(e.fv));
      chk({n, ".fail_A"}, 32'(fa), 32'(e.fa));
      chk({n, ".fail_B"}, 32'(fb), 32'(e.fb));
      chk({n, ".fail_S"}, 32'(fs), 32'(e.fs));
    end
    chk({n, ".done_edge"}, cyc, e.at);
  endtask

  always @(negedge clk) begin
    if (dn0 && !pd0) begin
      if (q0.size() == 0) chk("u0.unexpected_done", 1, 0);
      else score("u0", q0.pop_front(), er0, ps0, fv0, fa0, fb0, fs0);
    end
    if (dn1 && !pd1) begin
      if (q1q.size() == 0) chk("u1.unexpected_done", 1, 0);
      else score("u1", q1q.pop_front(), er1, ps1, fv1, fa1, fb1, fs1);
    end
    if (dn2 && !pd2) begin
      if (q2q.size() == 0) chk("u2.unexpected_done", 1, 0);
      else score("u2", q2q.pop_front(), {12'd0, er2}, ps2, fv2, fa2, fb2, fs2);
    end
    if (bz0) chk("u0.vector", 32'({a0, b0}), (cyc - e0_0 < 256) ? cyc - e0_0 : 255);
    pd0 <= dn0;
    pd1 <= dn1;
    pd2 <= dn2;
  end

  task automatic setst(input int w, input logic v);
    case (w)
      0: st0 = v;
      1: st1 = v;
      default: st2 = v;
    endcase
  endtask

  function automatic int qsize(input int w);
    return w == 0 ? q0.size() : w == 1 ? q1q.size() : q2q.size();
  endfunction

  task automatic go(input int w, input bit pulse);
    exp_t e;
    int cnt, sat, lat;
    logic [4:0] g, good;
    logic bz, dn, fv;
    logic [15:0] er;
    e = '0;
    cnt = 0;
    sat = (w == 2) ? 15 : 65535;
    lat = (w == 1) ? 2 : 0;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) begin
        good = 5'(a + b);
        g = flt(good, fen, fbit, fval);
        if (g != good) begin
          cnt++;
          if (!e.fv) begin
            e.fv = 1;
            e.fa = 4'(a);
            e.fb = 4'(b);
            e.fs = g;
          end
        end
      end
    e.err = 16'(cnt > sat ? sat : cnt);
    e.nz = (w == 0) && isreg;
    @(negedge clk) setst(w, 1);
    @(posedge clk);
    #1 setst(w, 0);
    e.at = cyc + 257 + lat;
    if (w == 0) e0_0 = cyc;
    case (w)
      0: begin q0.push_back(e); {bz, dn, fv, er} = {bz0, dn0, fv0, er0}; end
      1: begin q1q.push_back(e); {bz, dn, fv, er} = {bz1, dn1, fv1, er1}; end
      default: begin q2q.push_back(e); {bz, dn, fv, er} = {bz2, dn2, fv2, 12'd0, er2}; end
    endcase
    chk("start.busy", 32'(bz), 1);
    chk("start.done", 32'(dn), 0);
    chk("start.errors", 32'(er), 0);
    chk("start.fail_valid", 32'(fv), 0);
    if (pulse) begin
      repeat (49) @(posedge clk);
      @(negedge clk) setst(w, 1);
      @(posedge clk);
      #1 setst(w, 0);
    end
  endtask

  task automatic finish_run(input int w);
    for (int t = 0; t < 400; t++) begin
      if (qsize(w) == 0) break;
      @(posedge clk);
    end
    if (qsize(w) != 0) begin
      chk("run_timeout", 32'(qsize(w)), 0);
      case (w)
        0: q0.delete();
        1: q1q.delete();
        default: q2q.delete();
      endcase
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t drop;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.A", 32'(a0), 0);
    chk("rst.B", 32'(b0), 0);
    chk("rst.busy", 32'(bz0), 0);
    chk("rst.done", 32'(dn0), 0);
    chk("rst.pass", 32'(ps0), 0);
    chk("rst.errors", 32'(er0), 0);
    chk("rst.fail_valid", 32'(fv0), 0);
    chk("rst.fail_ABS", 32'({fa0, fb0, fs0}), 0);
    chk("rst.u1_busy", 32'(bz1), 0);
    chk("rst.u2_done", 32'(dn2), 0);
    @(negedge clk) rst = 0;
    repeat (2) @(posedge clk);
    go(0, 0);
    finish_run(0);
    fen = 1; fbit = 0; fval = 0;
    go(0, 1);
    finish_run(0);
    chk("stuck0.errors", 32'(er0), 128);
    fen = 0;
    go(0, 0);
    finish_run(0);
    go(1, 0);
    finish_run(1);
    isreg = 1;
    go(0, 0);
    finish_run(0);
    isreg = 0;
    fen = 1; fbit = 0; fval = 0;
    go(2, 0);
    finish_run(2);
    chk("sat.errors", 32'(er2), 15);
    go(0, 0);
    repeat (99) @(posedge clk);
    @(negedge clk) rst = 1;
    @(posedge clk);
    #1 rst = 0;
    chk("midrst.A", 32'(a0), 0);
    chk("midrst.B", 32'(b0), 0);
    chk("midrst.busy", 32'(bz0), 0);
    chk("midrst.errors", 32'(er0), 0);
    chk("midrst.done", 32'(dn0), 0);
    if (q0.size() != 0) drop = q0.pop_front();
    fen = 0;
    repeat (3) @(posedge clk);
    go(0, 0);
    finish_run(0);
    for (int r = 0; r < 5; r++) begin
      int w;
      w = $urandom_range(0, 2);
      fen = 1'($urandom_range(0, 1));
      fbit = $urandom_range(0, 4);
      fval = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 5)) @(posedge clk);
      go(w, 1'($urandom_range(0, 1)));
      finish_run(w);
    end
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end
endmodule
